// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types, widths and segment patterns for the BCD display slice
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } calc_state_t;

    localparam int NUM_DIGITS = 3;
    localparam int BCD_W      = 4;
    localparam int DATA_W     = 8;
    localparam int SCRATCH_W  = NUM_DIGITS * BCD_W;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Double-dabble correction: every nibble >= 5 gets +3 so the next shift carries correctly
    function automatic logic [SCRATCH_W-1:0] dabble_adjust(input logic [SCRATCH_W-1:0] s);
        logic [SCRATCH_W-1:0] r;
        logic [BCD_W-1:0]     nib;
        r = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = s[i*BCD_W +: BCD_W];
            if (nib >= 4'd5) begin
                r[i*BCD_W +: BCD_W] = nib + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode_v.sv
// rtl/seg7_decode_v.sv - BCD digit to active-high seven-segment pattern
module seg7_decode_v
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Codes 10..15 cannot come out of the converter; they light nothing
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_bcd_display_v.sv
// rtl/calc_bcd_display_v.sv - serial binary-to-BCD converter driving a 3-digit scanned display (option: CALC_BCD_LEADING_ZERO_BLANK_EN)
module calc_bcd_display_v
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_W-1:0]    i_fu,
    input  logic                 i_load,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [SCRATCH_W-1:0] o_bcd,
    output logic [6:0]           o_seg,
    output logic [2:0]           o_an
);

    localparam logic [15:0] SCAN_MAX = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_POL  = {7{SEG_ACTIVE_LOW}};
    localparam logic [2:0]  AN_POL   = {3{SEG_ACTIVE_LOW}};

    calc_state_t          state;
    logic [DATA_W-1:0]    shreg;
    logic [SCRATCH_W-1:0] scratch;
    logic [SCRATCH_W-1:0] scratch_adj;
    logic [2:0]           bit_cnt;

    logic [15:0]          scan_cnt;
    logic [1:0]           digit_idx;
    logic [BCD_W-1:0]     cur_digit;
    logic [2:0]           an_onehot;
    logic [6:0]           seg_raw;
    logic                 blank;

    assign scratch_adj = dabble_adjust(scratch);

    // Conversion FSM: capture, eight adjust-and-shift steps, then publish the result
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            bit_cnt <= '0;
            o_bcd   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_load) begin
                        shreg   <= i_fu;
                        scratch <= '0;
                        bit_cnt <= '0;
                        o_busy  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= {scratch_adj[SCRATCH_W-2:0], shreg, 1'b0};
                    bit_cnt          <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    o_bcd  <= scratch;
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Scan timer: each digit is held for REFRESH_DIV clocks, then the next one is enabled
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    // Pick the digit of the last completed result for the enabled position
    always_comb begin
        cur_digit = o_bcd[3:0];
        an_onehot = 3'b001;
        case (digit_idx)
            2'd1: begin
                cur_digit = o_bcd[7:4];
                an_onehot = 3'b010;
            end
            2'd2: begin
                cur_digit = o_bcd[11:8];
                an_onehot = 3'b100;
            end
            default: begin
                cur_digit = o_bcd[3:0];
                an_onehot = 3'b001;
            end
        endcase
    end

`ifdef CALC_BCD_LEADING_ZERO_BLANK_EN
    // Suppress leading zeros; the ones digit always shows
    always_comb begin
        blank = 1'b0;
        if (digit_idx == 2'd2 && o_bcd[11:8] == 4'd0) begin
            blank = 1'b1;
        end
        if (digit_idx == 2'd1 && o_bcd[11:4] == 8'd0) begin
            blank = 1'b1;
        end
    end
`else
    assign blank = 1'b0;
`endif

    seg7_decode_v u_decode (
        .bcd (cur_digit),
        .seg (seg_raw)
    );

    // Anode and segment outputs registered together so they always switch on the same edge
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_an  <= AN_POL ^ 3'b001;
            o_seg <= SEG_POL ^ SEG_0;
        end else begin
            o_an  <= AN_POL ^ an_onehot;
            o_seg <= SEG_POL ^ (blank ? SEG_BLANK : seg_raw);
        end
    end

endmodule

// File: tb/tb_calc_bcd_display_v.sv
// tb/tb_calc_bcd_display_v.sv - scoreboard bench for calc_bcd_display_v
module tb_calc_bcd_display_v;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  fu = 8'd0;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    calc_bcd_display_v #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_fu    (fu),
        .i_load  (load),
        .o_busy  (busy),
        .o_done  (done),
        .o_bcd   (bcd),
        .o_seg   (seg),
        .o_an    (an)
    );

    function automatic logic [11:0] model_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] model_seg(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic do_load(input int v);
        @(negedge clk);
        fu = v[7:0];
        load = 1'b1;
        exp_q.push_back(model_bcd(v));
        @(negedge clk);
        load = 1'b0;
        fu = 8'($urandom);
    endtask

    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (!done && cycles < 30) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++; if (an !== 3'b110) begin n_fail++; $display("FAIL reset_an got=%b exp=110", an); end
        n_tests++; if (seg !== ~model_seg(0)) begin n_fail++; $display("FAIL reset_seg got=%b exp=%b", seg, ~model_seg(0)); end
    endtask

    task automatic test_zero();
        int c, b;
        logic [11:0] e;
        do_load(0);
        wait_done(c, b);
        n_tests++; if (c !== 9) begin n_fail++; $display("FAIL zero_latency got=%0d exp=9", c); end
        n_tests++; if (b !== 9) begin n_fail++; $display("FAIL zero_busy_cycles got=%0d exp=9", b); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        n_tests++; if (bcd !== e) begin n_fail++; $display("FAIL zero_bcd got=%h exp=%h", bcd, e); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse_width got=%b exp=0", done); end
    endtask

    task automatic test_values();
        int vals[3] = '{195, 255, 211};
        int c, b;
        logic [11:0] e;
        for (int i = 0; i < 3; i++) begin
            do_load(vals[i]);
            wait_done(c, b);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            n_tests++;
            if (c >= 30 || bcd !== e) begin
                n_fail++;
                $display("FAIL value_%0d got=%h exp=%h cycles=%0d", vals[i], bcd, e, c);
            end
        end
    endtask

    task automatic test_ignore_load();
        int dones = 0;
        logic [11:0] got = 12'h000;
        logic [11:0] e;
        do_load(42);
        @(negedge clk);
        fu = 8'd99;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (done) begin
                dones++;
                got = bcd;
            end
            @(negedge clk);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL ignore_bcd got=%h exp=%h", got, e); end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        int c, b;
        logic [11:0] e;
        do_load(100);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL abort_bcd got=%h exp=000", bcd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        for (int k = 0; k < 15; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        do_load(7);
        wait_done(c, b);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        n_tests++; if (c >= 30 || bcd !== e) begin n_fail++; $display("FAIL abort_reload got=%h exp=%h", bcd, e); end
    endtask

    task automatic test_back_to_back();
        int vals[3] = '{12, 250, 99};
        int c, b;
        logic [11:0] e;
        do_load(vals[0]);
        for (int i = 0; i < 3; i++) begin
            wait_done(c, b);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            n_tests++;
            if (c !== 9 || bcd !== e) begin
                n_fail++;
                $display("FAIL b2b_%0d got=%h exp=%h cycles=%0d exp_cycles=9", i, bcd, e, c);
            end
            if (i < 2) begin
                fu = vals[i+1][7:0];
                load = 1'b1;
                exp_q.push_back(model_bcd(vals[i+1]));
                @(negedge clk);
                load = 1'b0;
            end
        end
    endtask

    task automatic test_display(input int v);
        int c, b;
        int found = 0;
        int digs[3];
        logic [2:0] an_exp[3] = '{3'b110, 3'b101, 3'b011};
        logic [2:0] prev;
        logic [6:0] seg_exp;
        logic [11:0] e;
        digs[0] = v % 10;
        digs[1] = (v / 10) % 10;
        digs[2] = v / 100;
        do_load(v);
        wait_done(c, b);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        n_tests++; if (bcd !== e) begin n_fail++; $display("FAIL disp_%0d_bcd got=%h exp=%h", v, bcd, e); end
        prev = an;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (prev !== 3'b110 && an === 3'b110) found = 1;
            prev = an;
        end
        n_tests++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL disp_%0d_scan_start got=%b exp=110", v, an);
        end else begin
            for (int d = 0; d < 3; d++) begin
                seg_exp = ~model_seg(digs[d]);
`ifdef CALC_BCD_LEADING_ZERO_BLANK_EN
                if (d == 2 && digs[2] == 0) seg_exp = 7'b1111111;
                if (d == 1 && digs[2] == 0 && digs[1] == 0) seg_exp = 7'b1111111;
`endif
                for (int s = 0; s < 4; s++) begin
                    n_tests++;
                    if (an !== an_exp[d] || seg !== seg_exp) begin
                        n_fail++;
                        $display("FAIL disp_%0d_digit%0d_cyc%0d an=%b seg=%b exp_an=%b exp_seg=%b",
                                 v, d, s, an, seg, an_exp[d], seg_exp);
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_ignore_load();
        test_reset_abort();
        test_back_to_back();
        test_display(195);
        test_display(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
